// File: rtl/fmul_rr_arbiter.sv
// ============================================================================
// fmul_rr_arbiter: round-robin share of one FP32 multiplier core among N_REQ
// requesters. Optional BUSY abort timer enabled by FMUL_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fmul_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  op1_flat,
    input  logic [32*N_REQ-1:0]  op2_flat,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mul_ready,
    output logic [31:0]          mul_op1,
    output logic [31:0]          mul_op2,
    input  logic                 mul_done,
    input  logic [31:0]          mul_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    if (IDX_W != $clog2(N_REQ)) begin : g_bad_idx_w
        $error("IDX_W must equal ceil(log2(N_REQ))");
    end
    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
        $error("TIMEOUT must lie in 2..256");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_rsp_valid_nxt;
    logic [31:0]        w_rsp_data_nxt;
    logic               w_ready_nxt;
    logic [31:0]        w_op1_nxt;
    logic [31:0]        w_op2_nxt;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
`ifdef FMUL_ARB_TIMEOUT_EN
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               r_rsp_err;
    logic               w_rsp_err_nxt;
`endif

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_idx_nxt       = r_idx;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = rsp_data;
        w_ready_nxt     = mul_ready;
        w_op1_nxt       = mul_op1;
        w_op2_nxt       = mul_op2;
`ifdef FMUL_ARB_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_rsp_err_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_idx_nxt            = w_winner;
                    w_gnt_nxt[w_winner]  = 1'b1;
                    w_op1_nxt            = op1_flat[32*w_winner +: 32];
                    w_op2_nxt            = op2_flat[32*w_winner +: 32];
                    w_ready_nxt          = 1'b1;
                    w_ptr_nxt            = (w_winner == IDX_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;
                    w_state_nxt          = ST_BUSY;
`ifdef FMUL_ARB_TIMEOUT_EN
                    w_cnt_nxt            = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    w_rsp_data_nxt         = mul_res;
                    w_rsp_valid_nxt[r_idx] = 1'b1;
                    w_ready_nxt            = 1'b0;
                    w_state_nxt            = ST_RESP;
                end
`ifdef FMUL_ARB_TIMEOUT_EN
                else if (r_cnt == 8'(TIMEOUT-1)) begin
                    w_rsp_data_nxt         = C_QNAN;
                    w_rsp_valid_nxt[r_idx] = 1'b1;
                    w_rsp_err_nxt          = 1'b1;
                    w_ready_nxt            = 1'b0;
                    w_state_nxt            = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
`endif
            end
            // Hold here until the core drops done so it is not re-taken as a completion.
            ST_RESP: begin
                if (!mul_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mul_ready <= 1'b0;
            mul_op1   <= '0;
            mul_op2   <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            gnt       <= w_gnt_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_data  <= w_rsp_data_nxt;
            mul_ready <= w_ready_nxt;
            mul_op1   <= w_op1_nxt;
            mul_op2   <= w_op2_nxt;
`ifdef FMUL_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_rsp_err <= w_rsp_err_nxt;
`endif
        end
    end

    assign busy = (r_state != ST_IDLE);

`ifdef FMUL_ARB_TIMEOUT_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmul_rr_arbiter.sv
// ============================================================================
// tb_fmul_rr_arbiter: table-driven scenarios with a behavioural core and a
// grant/response scoreboard. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fmul_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    req;
    logic [32*N-1:0] op1_flat;
    logic [32*N-1:0] op2_flat;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            mul_ready;
    logic [31:0]     mul_op1;
    logic [31:0]     mul_op2;
    logic            mul_done;
    logic [31:0]     mul_res;

    always #5 pclk = ~pclk;

    fmul_rr_arbiter #(.N_REQ(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn), .req(req),
        .op1_flat(op1_flat), .op2_flat(op2_flat),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_done(mul_done), .mul_res(mul_res)
    );

    // Requester operands and hand-computed IEEE-754 products.
    logic [31:0] a_op[N]     = '{32'h3FC00000, 32'h40000000, 32'hC0000000, 32'h40800000};
    logic [31:0] b_op[N]     = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] exp_prod[N] = '{32'h40400000, 32'h40800000, 32'hC0C00000, 32'h41800000};

    typedef struct {
        bit       rst_first;
        logic [3:0] req;
        logic [3:0] hold;
        int       lat;
        int       drop;
        int       n;
        int       ord[4];
        bit       tmo;
    } scn_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
        int          t_gnt;
    } sb_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat, drop, grants_left, last_rsp;
    bit          tmo_mode;
    logic [3:0]  hold;
    int          exp_ord[$];
    sb_t         sbq[$];
    logic [N-1:0] prev_gnt, prev_rsp;
    logic [31:0] last_data;
    int          ccnt, dcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int first_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] core_mul(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) if (a == a_op[i] && b == b_op[i]) return exp_prod[i];
        return 32'hDEADBEEF;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"},       gnt, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"},  rsp_data, 0);
        chk({tag, "_rsp_err"},   rsp_err, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_mul_ready"}, mul_ready, 0);
        chk({tag, "_mul_op1"},   mul_op1, 0);
        chk({tag, "_mul_op2"},   mul_op2, 0);
    endtask

    // One clock: monitor/scoreboard, then the behavioural core, all #1 after the edge.
    task automatic step();
        int  gi, ri;
        sb_t e;
        @(posedge pclk);
        #1;
        cyc++;
        if (gnt != 0) begin
            gi = first_idx(gnt);
            chk("gnt_onehot", 32'($onehot(gnt)), 1);
            chk("gnt_single_cycle", prev_gnt, 0);
            chk("gnt_rsp_exclusive", rsp_valid, 0);
            if (exp_ord.size() == 0) fail("gnt_unexpected");
            else chk("gnt_idx", gi, exp_ord.pop_front());
            chk("gnt_mul_ready", mul_ready, 1);
            chk("gnt_busy", busy, 1);
            chk("gnt_mul_op1", mul_op1, a_op[gi]);
            chk("gnt_mul_op2", mul_op2, b_op[gi]);
            if (last_rsp >= 0) chk("b2b_gap", cyc - last_rsp, 2 + drop);
            e.idx = gi; e.t_gnt = cyc;
            e.data = tmo_mode ? 32'h7FC00000 : exp_prod[gi];
            e.err  = tmo_mode;
            sbq.push_back(e);
            grants_left--;
            if (grants_left == 0) req = '0;
        end
        if (rsp_valid != 0) begin
            ri = first_idx(rsp_valid);
            chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
            chk("rsp_single_cycle", prev_rsp, 0);
            chk("rsp_mul_ready_low", mul_ready, 0);
            if (sbq.size() == 0) fail("rsp_unexpected");
            else begin
                e = sbq.pop_front();
                chk("rsp_idx", ri, e.idx);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_latency", cyc - e.t_gnt, tmo_mode ? TO : lat + 1);
            end
            last_rsp  = cyc;
            last_data = rsp_data;
            if (!hold[ri]) req[ri] = 1'b0;
        end else if (prev_rsp != 0) begin
            chk("rsp_data_hold", rsp_data, last_data);
        end
        prev_gnt = gnt;
        prev_rsp = rsp_valid;
        if (mul_ready && !mul_done) begin
            if (ccnt >= lat) begin
                mul_done = 1'b1;
                mul_res  = core_mul(mul_op1, mul_op2);
                ccnt = 0;
                dcnt = 0;
            end else ccnt++;
        end else if (!mul_ready && mul_done) begin
            if (dcnt >= drop) mul_done = 1'b0;
            else dcnt++;
        end else if (!mul_ready) begin
            ccnt = 0;
        end
    endtask

    task automatic do_reset();
        presetn  = 1'b1;
        req      = '0;
        mul_done = 1'b0;
        mul_res  = '0;
        ccnt = 0; dcnt = 0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
        prev_gnt = '0;
        prev_rsp = '0;
    endtask

    task automatic run_scn(input scn_t s);
        int t;
        if (s.rst_first) do_reset();
        lat = s.lat; drop = s.drop; hold = s.hold; tmo_mode = s.tmo;
        last_rsp = -1;
        grants_left = s.n;
        exp_ord.delete();
        sbq.delete();
        for (int i = 0; i < s.n; i++) exp_ord.push_back(s.ord[i]);
        req = s.req;
        t = 0;
        do begin
            step();
            t++;
        end while ((grants_left > 0 || sbq.size() > 0 || busy) && t < 500);
        if (t >= 500) fail("scenario_cycle_budget");
        chk("scn_grants_left", exp_ord.size(), 0);
        chk("scn_rsp_left", sbq.size(), 0);
        req = '0;
    endtask

    scn_t scn[6];

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            op1_flat[32*i +: 32] = a_op[i];
            op2_flat[32*i +: 32] = b_op[i];
        end
        //         rst   req      hold     lat drop n  order          tmo
        scn[0] = '{1'b0, 4'b0001, 4'b0000, 3,  0,   1, '{0, 0, 0, 0}, 1'b0};
        scn[1] = '{1'b1, 4'b1111, 4'b0000, 2,  0,   4, '{0, 1, 2, 3}, 1'b0};
        scn[2] = '{1'b0, 4'b0011, 4'b0011, 1,  0,   4, '{0, 1, 0, 1}, 1'b0};
        scn[3] = '{1'b0, 4'b0011, 4'b0011, 0,  3,   2, '{0, 1, 0, 0}, 1'b0};
        scn[4] = '{1'b0, 4'b1010, 4'b0000, 4,  0,   2, '{3, 1, 0, 0}, 1'b0};
        scn[5] = '{1'b0, 4'b1100, 4'b1100, 0,  1,   3, '{2, 3, 2, 0}, 1'b0};

        presetn = 1'b1;
        req = '0; mul_done = 1'b0; mul_res = '0;
        ccnt = 0; dcnt = 0; prev_gnt = '0; prev_rsp = '0;
        lat = 0; drop = 0; hold = '0; tmo_mode = 1'b0; last_rsp = -1; grants_left = 0;
        last_data = '0;
        #2;
        chk_zero_outputs("reset");
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;

        for (int i = 0; i < 6; i++) run_scn(scn[i]);

        // Reset in the middle of BUSY: outputs drop at once, result is discarded.
        do_reset();
        lat = 50; drop = 0; hold = '0; tmo_mode = 1'b0; last_rsp = -1; grants_left = 1;
        exp_ord.delete(); sbq.delete();
        exp_ord.push_back(1);
        req = 4'b0010;
        repeat (4) step();
        chk("midop_busy_before", busy, 1);
        #3 presetn = 1'b1;
        #1;
        chk_zero_outputs("midop_reset");
        sbq.delete();
        req = '0; mul_done = 1'b0; ccnt = 0; dcnt = 0;
        prev_gnt = '0; prev_rsp = '0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
        // Stale ptr would pick 2 first; a fresh ptr=0 search picks 1.
        run_scn('{1'b0, 4'b0110, 4'b0000, 2, 0, 2, '{1, 2, 0, 0}, 1'b0});

`ifdef FMUL_ARB_TIMEOUT_EN
        run_scn('{1'b0, 4'b0100, 4'b0000, 1000, 0, 1, '{2, 0, 0, 0}, 1'b1});
        chk("tmo_mul_ready_after", mul_ready, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
